// File: rtl/karatsuba_product_serializer.sv
// Captures a full 2N-bit Karatsuba product in one handshake and streams it
// out least-significant word first as W-bit words over a second handshake.
module karatsuba_product_serializer #(
    parameter int unsigned N = 16384,
    parameter int unsigned W = 64,
    localparam int unsigned WORDS = (2 * N) / W,
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IW-1:0]    out_idx,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [2*N-1:0]  hold_q;
    logic            capture;
    logic            at_last;
    logic [31:0]     bit_base;

    assign at_last   = (state_q == StSend) && (idx_q == LastIdx);
    // A new product may enter in the same cycle the last word leaves.
    assign in_ready  = (state_q == StIdle) || (at_last && out_ready);
    assign capture   = in_valid && in_ready;
    assign out_valid = (state_q == StSend);
    assign busy      = (state_q == StSend);
    assign out_last  = at_last;
    assign bit_base  = 32'(idx_q) * W;

    // Word select from the holding register; zero whenever nothing is held.
    always_comb begin
        out_data = '0;
        out_idx  = '0;
        if (state_q == StSend) begin
            out_data = hold_q[bit_base +: W];
            out_idx  = idx_q;
        end
    end

    // Next-state and word-index logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    state_d = StSend;
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (at_last) begin
                        idx_d   = '0;
                        state_d = in_valid ? StSend : StIdle;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // State and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Product holding register, loaded only on an input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= in_prod;
        end
    end

endmodule

// File: tb/tb_karatsuba_product_serializer.sv
// Self-checking bench: three serializer configurations checked every cycle
// against queue-based models, plus directed literal sequences.
module tb_karatsuba_product_serializer;

    localparam int unsigned NA = 8;
    localparam int unsigned WA = 4;
    localparam int unsigned NB = 4;
    localparam int unsigned WB = 8;
    localparam int unsigned NC = 16384;
    localparam int unsigned WC = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=8, W=4 (4 words)
    logic a_iv = 0, a_ir, a_ov, a_or = 0, a_last, a_busy;
    logic [15:0] a_prod = '0;
    logic [3:0] a_od;
    logic [1:0] a_oidx;
    // Instance B: N=4, W=8 (1 word)
    logic b_iv = 0, b_ir, b_ov, b_or = 0, b_last, b_busy;
    logic [7:0] b_prod = '0;
    logic [7:0] b_od;
    logic [0:0] b_oidx;
    // Instance C: full width (512 words)
    logic c_iv = 0, c_ir, c_ov, c_or = 1, c_last, c_busy;
    logic [2*NC-1:0] c_prod = '0;
    logic [WC-1:0] c_od;
    logic [8:0] c_oidx;

    karatsuba_product_serializer #(.N(NA), .W(WA)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_prod(a_prod),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_idx(a_oidx),
        .out_last(a_last), .busy(a_busy));

    karatsuba_product_serializer #(.N(NB), .W(WB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_prod(b_prod),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_idx(b_oidx),
        .out_last(b_last), .busy(b_busy));

    karatsuba_product_serializer #(.N(NC), .W(WC)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_prod(c_prod),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_idx(c_oidx),
        .out_last(c_last), .busy(c_busy));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Models: a queue of words still owed to the consumer. Outputs follow
    // from the queue front; the owed count gives index and last flag.
    logic [3:0] a_q[$];
    logic [3:0] a_log[$];
    logic a_fresh = 1'b1, a_mrdy = 1'b1;
    logic [7:0] b_q[$];
    logic [7:0] b_log[$];
    logic b_fresh = 1'b1, b_mrdy = 1'b1;

    // Model update on the active edge; also logs DUT-accepted words.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q.delete();
            b_q.delete();
            a_fresh <= 1'b1;
            b_fresh <= 1'b1;
        end else begin
            if (a_ov && a_or) a_log.push_back(a_od);
            if (b_ov && b_or) b_log.push_back(b_od);
            if (a_q.size() > 0 && a_or) void'(a_q.pop_front());
            if (a_iv && a_mrdy) begin
                for (int i = 0; i < 4; i++) a_q.push_back(a_prod[i*4 +: 4]);
                a_fresh <= 1'b0;
            end
            if (b_q.size() > 0 && b_or) void'(b_q.pop_front());
            if (b_iv && b_mrdy) begin
                b_q.push_back(b_prod);
                b_fresh <= 1'b0;
            end
        end
    end

    // Compare DUT outputs against the models away from the active edge.
    always @(negedge clk) begin
        a_mrdy <= (a_q.size() == 0) || (a_q.size() == 1 && a_or);
        b_mrdy <= (b_q.size() == 0) || (b_q.size() == 1 && b_or);
        check("a_in_ready", 64'(a_ir), 64'((a_q.size() == 0) || (a_q.size() == 1 && a_or)));
        check("a_out_valid", 64'(a_ov), 64'(a_q.size() > 0));
        check("a_busy", 64'(a_busy), 64'(a_q.size() > 0));
        if (a_q.size() > 0) begin
            check("a_data", 64'(a_od), 64'(a_q[0]));
            check("a_idx", 64'(a_oidx), 64'(4 - a_q.size()));
            check("a_last", 64'(a_last), 64'(a_q.size() == 1));
        end else if (a_fresh) begin
            check("a_idle_zero", {a_od, a_oidx, a_last}, 64'd0);
        end
        check("b_in_ready", 64'(b_ir), 64'((b_q.size() == 0) || (b_q.size() == 1 && b_or)));
        check("b_out_valid", 64'(b_ov), 64'(b_q.size() > 0));
        check("b_busy", 64'(b_busy), 64'(b_q.size() > 0));
        if (b_q.size() > 0) begin
            check("b_data", 64'(b_od), 64'(b_q[0]));
            check("b_idx", 64'(b_oidx), 64'd0);
            check("b_last", 64'(b_last), 64'd1);
        end else if (b_fresh) begin
            check("b_idle_zero", {b_od, b_oidx, b_last}, 64'd0);
        end
    end

    // Full-width stream: expected word is a slice of the reference product.
    logic [2*NC-1:0] c_ref = '0;
    int c_idx = 0;

    always @(negedge clk) begin
        if (c_ov) begin
            check("c_data", c_od, c_ref[c_idx*WC +: WC]);
            check("c_idx", 64'(c_oidx), 64'(c_idx));
            check("c_last", 64'(c_last), 64'(c_idx == 511));
        end
    end

    always @(posedge clk) begin
        if (c_ov && c_or) c_idx <= c_idx + 1;
    end

    initial begin
        #12;
        check("reset_in_ready", 64'(a_ir), 64'd1);
        check("reset_out_valid", 64'(a_ov), 64'd0);
        check("reset_out_data", 64'(a_od), 64'd0);
        check("reset_busy", 64'(a_busy), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1);

        // Full-width product, in_prod scrambled after capture.
        for (int i = 0; i < 1024; i++) c_ref[i*32 +: 32] = $urandom;
        c_prod = c_ref;
        c_iv = 1'b1;
        cyc(1);
        c_iv = 1'b0;
        for (int i = 0; i < 1024; i++) c_prod[i*32 +: 32] = $urandom;
        for (int i = 0; i < 600 && c_idx < 512; i++) cyc(1);
        check("c_word_count", 64'(c_idx), 64'd512);
        check("c_done_idle", 64'(c_ov), 64'd0);

        // Single product, free-flowing output.
        a_log.delete();
        a_prod = 16'hBEEF; a_iv = 1'b1; a_or = 1'b1;
        cyc(1);
        a_iv = 1'b0; a_prod = 16'(($urandom));
        cyc(6);
        check("beef_count", 64'(a_log.size()), 64'd4);
        check("beef_w0", 64'(a_log[0]), 64'hF);
        check("beef_w1", 64'(a_log[1]), 64'hE);
        check("beef_w2", 64'(a_log[2]), 64'hE);
        check("beef_w3", 64'(a_log[3]), 64'hB);
        check("beef_idle_ready", 64'(a_ir), 64'd1);

        // Backpressure while word 1 is presented.
        a_log.delete();
        a_prod = 16'hBEEF; a_iv = 1'b1; a_or = 1'b1;
        cyc(1);
        a_iv = 1'b0;
        cyc(1);
        a_or = 1'b0;
        repeat (3) begin
            cyc(1);
            check("bp_valid", 64'(a_ov), 64'd1);
            check("bp_data", 64'(a_od), 64'hE);
            check("bp_idx", 64'(a_oidx), 64'd1);
        end
        a_or = 1'b1;
        cyc(6);
        check("bp_count", 64'(a_log.size()), 64'd4);
        check("bp_seq", {a_log[0], a_log[1], a_log[2], a_log[3]}, 64'hFEEB);

        // Back-to-back products with in_valid held high.
        a_log.delete();
        a_prod = 16'h1234; a_iv = 1'b1; a_or = 1'b1;
        cyc(1);
        a_prod = 16'hA5C3;
        cyc(4);
        a_iv = 1'b0;
        cyc(10);
        check("b2b_count", 64'(a_log.size()), 64'd8);
        check("b2b_seq", {a_log[0], a_log[1], a_log[2], a_log[3],
                          a_log[4], a_log[5], a_log[6], a_log[7]}, 64'h43213C5A);

        // Single-word products, one per cycle.
        b_log.delete();
        b_or = 1'b1; b_iv = 1'b1; b_prod = 8'h3C;
        cyc(1);
        b_prod = 8'hFF;
        cyc(1);
        b_prod = 8'h00;
        cyc(1);
        b_iv = 1'b0;
        cyc(3);
        check("w1_count", 64'(b_log.size()), 64'd3);
        check("w1_seq", {b_log[0], b_log[1], b_log[2]}, 64'h3CFF00);

        // Asynchronous reset in the middle of a stream.
        a_log.delete();
        a_prod = 16'hBEEF; a_iv = 1'b1; a_or = 1'b1;
        cyc(1);
        a_iv = 1'b0;
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(a_ov), 64'd0);
        check("rst_out_data", 64'(a_od), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_in_ready", 64'(a_ir), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(6);
        check("rst_words_before", 64'(a_log.size()), 64'd2);
        check("rst_after_ready", 64'(a_ir), 64'd1);
        check("rst_after_valid", 64'(a_ov), 64'd0);

        // Randomized traffic on both small instances.
        repeat (600) begin
            a_iv = 1'($urandom_range(0, 1));
            a_prod = 16'($urandom);
            a_or = ($urandom_range(0, 3) != 0);
            b_iv = 1'($urandom_range(0, 1));
            b_prod = 8'($urandom);
            b_or = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        a_iv = 1'b0; b_iv = 1'b0; a_or = 1'b1; b_or = 1'b1;
        cyc(8);
        check("drain_a", 64'(a_ov), 64'd0);
        check("drain_b", 64'(b_ov), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
